// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: ownership state
// encoding and grant-source tags.
package dmem_port_arbiter_pkg;

   // Memory ownership: CPU by default, EXT while a burst is in progress.
   typedef enum logic {
      S_CPU = 1'b0,
      S_EXT = 1'b1
   } arb_state_t;

   // Which requester drives the memory in the current cycle.
   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_CPU  = 2'd1,
      GNT_EXT  = 2'd2
   } gnt_src_t;

   // Bits needed to hold a counter that saturates at limit.
   function automatic int cnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/dmem_port_arbiter_mux.sv
// Generic 2:1 selector used for the memory address and write-data paths.
// sel=0 passes a, sel=1 passes b.
module mux_2_to_1 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic [WIDTH-1:0] y
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
         assign y[gi] = sel ? b[gi] : a[gi];
      end
   endgenerate

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbiter sharing the single-port data memory between the pipeline MEM
// stage (CPU, priority) and an external loader/debug master (EXT).
// EXT is protected from starvation and may own the memory for bursts of
// up to BURST_MAX beats.
// Optional build macro: DMEM_ARB_PERF_CNT_EN adds a CPU stall-cycle counter
// on o_StallCount; without it o_StallCount is tied to zero.
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int STARVE_LIMIT  = 4,
   parameter int BURST_MAX     = 4
) (
   input  logic                     i_CLK,
   input  logic                     i_RST,
   input  logic                     i_CpuReq,
   input  logic                     i_CpuWe,
   input  logic [ADDRESS_WIDTH-1:0] i_CpuAddr,
   input  logic [DATA_WIDTH-1:0]    i_CpuWData,
   output logic [DATA_WIDTH-1:0]    o_CpuRData,
   output logic                     o_CpuStall,
   input  logic                     i_ExtReq,
   input  logic                     i_ExtWe,
   input  logic [ADDRESS_WIDTH-1:0] i_ExtAddr,
   input  logic [DATA_WIDTH-1:0]    i_ExtWData,
   output logic                     o_ExtGnt,
   output logic [DATA_WIDTH-1:0]    o_ExtRData,
   output logic                     o_ExtRValid,
   output logic                     o_MemWe,
   output logic [ADDRESS_WIDTH-1:0] o_MemAddr,
   output logic [DATA_WIDTH-1:0]    o_MemWData,
   input  logic [DATA_WIDTH-1:0]    i_MemRData,
   output logic [31:0]              o_StallCount
);

   localparam int SW = cnt_width(STARVE_LIMIT);
   localparam int BW = cnt_width(BURST_MAX);
   localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT);
   localparam logic [BW-1:0] BURST_TOP  = BW'(BURST_MAX);

   arb_state_t    state_reg, state_next;
   logic [SW-1:0] starve_cnt_reg, starve_cnt_next;
   logic [BW-1:0] beat_cnt_reg, beat_cnt_next;
   gnt_src_t      gnt_src;
   logic          cpu_gnt;
   logic          ext_gnt;
   logic          ext_rvalid_reg;
   logic [DATA_WIDTH-1:0] ext_rdata_reg;

   // Grant selection: CPU wins ties unless EXT has been starved to the limit;
   // inside a burst EXT keeps the memory until it drops or hits BURST_MAX.
   always_comb begin
      gnt_src = GNT_NONE;
      if (state_reg == S_CPU) begin
         if (i_ExtReq && (!i_CpuReq || (starve_cnt_reg == STARVE_TOP)))
            gnt_src = GNT_EXT;
         else if (i_CpuReq)
            gnt_src = GNT_CPU;
      end else begin
         if (i_ExtReq && (beat_cnt_reg < BURST_TOP))
            gnt_src = GNT_EXT;
         else if (i_CpuReq)
            gnt_src = GNT_CPU;
      end
   end

   assign cpu_gnt = (gnt_src == GNT_CPU);
   assign ext_gnt = (gnt_src == GNT_EXT);

   // Address and write data follow EXT only when it holds the grant;
   // otherwise the CPU inputs are presented, which is harmless with We low.
   mux_2_to_1 #(.WIDTH(ADDRESS_WIDTH)) u_addr_mux (
      .a   (i_CpuAddr),
      .b   (i_ExtAddr),
      .sel (ext_gnt),
      .y   (o_MemAddr)
   );

   mux_2_to_1 #(.WIDTH(DATA_WIDTH)) u_wdata_mux (
      .a   (i_CpuWData),
      .b   (i_ExtWData),
      .sel (ext_gnt),
      .y   (o_MemWData)
   );

   // Write enable comes from the granted side and is suppressed in reset.
   assign o_MemWe    = !i_RST && ((ext_gnt && i_ExtWe) || (cpu_gnt && i_CpuWe));
   assign o_CpuStall = i_CpuReq && !cpu_gnt;
   assign o_ExtGnt   = ext_gnt;
   assign o_CpuRData = i_MemRData;
   assign o_ExtRData = ext_rdata_reg;
   assign o_ExtRValid = ext_rvalid_reg;

   // Next ownership state, burst beat count and starvation count.
   always_comb begin
      state_next      = state_reg;
      beat_cnt_next   = beat_cnt_reg;
      starve_cnt_next = starve_cnt_reg;

      if (state_reg == S_CPU) begin
         if (ext_gnt) begin
            state_next    = S_EXT;
            beat_cnt_next = BW'(1);
         end
      end else begin
         if (ext_gnt) begin
            beat_cnt_next = beat_cnt_reg + 1'b1;
         end else begin
            // Burst over (EXT dropped or hit the limit); the waiting CPU has
            // already been granted this cycle by the selection logic.
            state_next    = S_CPU;
            beat_cnt_next = '0;
         end
      end

      if (!i_ExtReq || ext_gnt)
         starve_cnt_next = '0;
      else if (starve_cnt_reg != STARVE_TOP)
         starve_cnt_next = starve_cnt_reg + 1'b1;
   end

   // State and counter registers.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_reg      <= S_CPU;
         beat_cnt_reg   <= '0;
         starve_cnt_reg <= '0;
      end else begin
         state_reg      <= state_next;
         beat_cnt_reg   <= beat_cnt_next;
         starve_cnt_reg <= starve_cnt_next;
      end
   end

   // EXT read response: capture memory data one edge after a read grant.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         ext_rvalid_reg <= 1'b0;
         ext_rdata_reg  <= '0;
      end else begin
         ext_rvalid_reg <= ext_gnt && !i_ExtWe;
         if (ext_gnt && !i_ExtWe)
            ext_rdata_reg <= i_MemRData;
      end
   end

`ifdef DMEM_ARB_PERF_CNT_EN
   logic [31:0] stall_count_reg;

   // Free-running count of CPU stall cycles, wrapping at 2^32.
   always_ff @(posedge i_CLK) begin
      if (i_RST)
         stall_count_reg <= '0;
      else if (o_CpuStall)
         stall_count_reg <= stall_count_reg + 32'd1;
   end

   assign o_StallCount = stall_count_reg;
`else
   assign o_StallCount = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed, table-driven bench for dmem_port_arbiter with a small
// behavioural memory attached to the memory port.
module tb_dmem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_stall;
   logic        ext_req, ext_we;
   logic [31:0] ext_addr, ext_wdata, ext_rdata;
   logic        ext_gnt, ext_rvalid;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [31:0] stall_count;

   logic [31:0] mem [0:255];
   logic        mem_clr;

   int n_cmp  = 0;
   int n_fail = 0;
   int exp_sc = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter #(
      .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .STARVE_LIMIT(4), .BURST_MAX(4)
   ) dut (
      .i_CLK(clk), .i_RST(rst),
      .i_CpuReq(cpu_req), .i_CpuWe(cpu_we), .i_CpuAddr(cpu_addr),
      .i_CpuWData(cpu_wdata), .o_CpuRData(cpu_rdata), .o_CpuStall(cpu_stall),
      .i_ExtReq(ext_req), .i_ExtWe(ext_we), .i_ExtAddr(ext_addr),
      .i_ExtWData(ext_wdata), .o_ExtGnt(ext_gnt), .o_ExtRData(ext_rdata),
      .o_ExtRValid(ext_rvalid), .o_MemWe(mem_we), .o_MemAddr(mem_addr),
      .o_MemWData(mem_wdata), .i_MemRData(mem_rdata), .o_StallCount(stall_count)
   );

   // Memory model: combinational read, write on the rising edge.
   assign mem_rdata = mem[mem_addr[7:0]];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int k = 0; k < 256; k++) mem[k] <= 32'd0;
      end else if (mem_we) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
   end

   typedef struct {
      logic        rst, cr, cw;
      logic [31:0] ca, cd;
      logic        er, ew;
      logic [31:0] ea, ed;
      logic        st, g, we;
      logic [31:0] ad;
      logic        ck;
      logic [31:0] crd;
      logic        rv;
      logic [31:0] rd;
   } vec_t;

   function automatic vec_t mk(
      input logic rst_i, cr, cw, input logic [31:0] ca, cd,
      input logic er, ew, input logic [31:0] ea, ed,
      input logic st, g, we, input logic [31:0] ad,
      input logic ck, input logic [31:0] crd, input logic rv, input logic [31:0] rd);
      vec_t v;
      v.rst = rst_i; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
      v.er = er; v.ew = ew; v.ea = ea; v.ed = ed;
      v.st = st; v.g = g; v.we = we; v.ad = ad;
      v.ck = ck; v.crd = crd; v.rv = rv; v.rd = rd;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst = v.rst; cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
      ext_req = v.er; ext_we = v.ew; ext_addr = v.ea; ext_wdata = v.ed;
   endtask

   function automatic logic [31:0] exp_stall_count();
`ifdef DMEM_ARB_PERF_CNT_EN
      return 32'(exp_sc);
`else
      return 32'd0;
`endif
   endfunction

   // Advance one clock, tracking the expected stall count for that edge.
   task automatic step(input logic was_rst, input logic was_stall);
      @(posedge clk);
      if (was_rst) exp_sc = 0;
      else if (was_stall) exp_sc++;
      #1;
   endtask

   vec_t tbl [30];

   initial begin
      // Cycle-by-cycle vectors: CPU-only, EXT-only, starvation + burst limit,
      // early burst exit, reset mid-burst and reset-dropped read response.
      tbl[0]  = mk(1,1,1,32'h30,32'h1111, 0,0,0,0,              0,0,0,32'h30, 0,0,0,0);
      tbl[1]  = mk(1,0,0,0,0,             1,1,32'h20,32'h99,    0,1,0,32'h20, 0,0,0,0);
      tbl[2]  = mk(0,0,0,0,0,             0,0,0,0,              0,0,0,0,      0,0,0,0);
      tbl[3]  = mk(0,1,1,32'h10,32'hDEADBEEF, 0,0,0,0,          0,0,1,32'h10, 0,0,0,0);
      tbl[4]  = mk(0,1,0,32'h10,0,        0,0,0,0,              0,0,0,32'h10, 1,32'hDEADBEEF,0,0);
      tbl[5]  = mk(0,1,0,32'h30,0,        0,0,0,0,              0,0,0,32'h30, 1,0,0,0);
      tbl[6]  = mk(0,0,0,0,0,             1,1,32'h20,32'h55,    0,1,1,32'h20, 0,0,0,0);
      tbl[7]  = mk(0,0,0,0,0,             1,0,32'h20,0,         0,1,0,32'h20, 0,0,0,0);
      tbl[8]  = mk(0,0,0,0,0,             0,0,0,0,              0,0,0,0,      0,0,1,32'h55);
      tbl[9]  = mk(0,0,0,0,0,             0,0,0,0,              0,0,0,0,      0,0,0,0);
      for (int i = 10; i <= 13; i++)
         tbl[i] = mk(0,1,0,32'h10,0,      1,0,32'h20,0,         0,0,0,32'h10, 1,32'hDEADBEEF,0,0);
      tbl[14] = mk(0,1,0,32'h10,0,        1,0,32'h20,0,         1,1,0,32'h20, 0,0,0,0);
      for (int i = 15; i <= 17; i++)
         tbl[i] = mk(0,1,0,32'h10,0,      1,0,32'h20,0,         1,1,0,32'h20, 0,0,1,32'h55);
      tbl[18] = mk(0,1,0,32'h10,0,        1,0,32'h20,0,         0,0,0,32'h10, 1,32'hDEADBEEF,1,32'h55);
      tbl[19] = mk(0,0,0,0,0,             0,0,0,0,              0,0,0,0,      0,0,0,0);
      tbl[20] = mk(0,0,0,0,0,             1,1,32'h40,32'hA1,    0,1,1,32'h40, 0,0,0,0);
      tbl[21] = mk(0,1,0,32'h40,0,        1,1,32'h41,32'hA2,    1,1,1,32'h41, 0,0,0,0);
      tbl[22] = mk(0,1,0,32'h40,0,        0,0,0,0,              0,0,0,32'h40, 1,32'hA1,0,0);
      tbl[23] = mk(0,1,0,32'h41,0,        0,0,0,0,              0,0,0,32'h41, 1,32'hA2,0,0);
      tbl[24] = mk(0,0,0,0,0,             1,0,32'h20,0,         0,1,0,32'h20, 0,0,0,0);
      tbl[25] = mk(1,0,0,0,0,             1,1,32'h50,32'h77,    0,1,0,32'h50, 0,0,1,32'h55);
      tbl[26] = mk(0,0,0,0,0,             0,0,0,0,              0,0,0,0,      0,0,0,0);
      tbl[27] = mk(0,1,0,32'h50,0,        1,0,32'h20,0,         0,0,0,32'h50, 1,0,0,0);
      tbl[28] = mk(1,0,0,0,0,             1,0,32'h20,0,         0,1,0,32'h20, 0,0,0,0);
      tbl[29] = mk(0,0,0,0,0,             0,0,0,0,              0,0,0,0,      0,0,0,0);

      // Initial reset with memory cleared.
      rst = 1'b1; mem_clr = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
      repeat (2) @(posedge clk);
      #1;
      mem_clr = 1'b0;
      exp_sc = 0;

      for (int i = 0; i < 30; i++) begin
         drive(tbl[i]);
         @(negedge clk);
         chk("cpu_stall", i, {31'd0, cpu_stall}, {31'd0, tbl[i].st});
         chk("ext_gnt",   i, {31'd0, ext_gnt},   {31'd0, tbl[i].g});
         chk("mem_we",    i, {31'd0, mem_we},    {31'd0, tbl[i].we});
         chk("mem_addr",  i, mem_addr, tbl[i].ad);
         if (tbl[i].we)
            chk("mem_wdata", i, mem_wdata, tbl[i].g ? tbl[i].ed : tbl[i].cd);
         if (tbl[i].ck)
            chk("cpu_rdata", i, cpu_rdata, tbl[i].crd);
         chk("ext_rvalid", i, {31'd0, ext_rvalid}, {31'd0, tbl[i].rv});
         if (tbl[i].rv)
            chk("ext_rdata", i, ext_rdata, tbl[i].rd);
         chk("stall_count", i, stall_count, exp_stall_count());
         $display("vec %0d: stall=%0b gnt=%0b we=%0b addr=%h rvalid=%0b",
                  i, cpu_stall, ext_gnt, mem_we, mem_addr, ext_rvalid);
         step(tbl[i].rst, tbl[i].st);
      end

      // Reset clears the held EXT read data as well as the valid flag.
      drive(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0));
      step(1'b1, 1'b0);
      drive(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0));
      @(negedge clk);
      chk("ext_rdata_rst", 100, ext_rdata, 32'd0);
      $display("post-reset: ext_rdata=%h", ext_rdata);
      step(1'b0, 1'b0);

      // EXT-only continuous reads: four-beat burst, one released cycle, then
      // EXT is granted again from S_CPU. Read data follows each grant.
      begin
         logic exp_g [6];
         logic prev_g;
         exp_g = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
         prev_g = 1'b0;
         for (int i = 0; i < 6; i++) begin
            drive(mk(0,0,0,0,0, 1,0,32'h40,0, 0,0,0,0, 0,0,0,0));
            @(negedge clk);
            chk("burst_gnt",    200 + i, {31'd0, ext_gnt},    {31'd0, exp_g[i]});
            chk("burst_stall",  200 + i, {31'd0, cpu_stall},  32'd0);
            chk("burst_rvalid", 200 + i, {31'd0, ext_rvalid}, {31'd0, prev_g});
            if (prev_g) chk("burst_rdata", 200 + i, ext_rdata, 32'hA1);
            $display("burst beat %0d: gnt=%0b rvalid=%0b rdata=%h", i, ext_gnt, ext_rvalid, ext_rdata);
            prev_g = exp_g[i];
            step(1'b0, 1'b0);
         end
      end

      // Stall accounting: reset, then both sides held for 8 cycles gives four
      // CPU grants followed by four stalled EXT beats.
      drive(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0));
      step(1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         drive(mk(0,1,0,32'h10,0, 1,0,32'h20,0, 0,0,0,0, 0,0,0,0));
         @(negedge clk);
         chk("starve_stall", 300 + i, {31'd0, cpu_stall}, (i >= 4) ? 32'd1 : 32'd0);
         $display("starve cycle %0d: stall=%0b gnt=%0b", i, cpu_stall, ext_gnt);
         step(1'b0, i >= 4);
      end
      drive(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0));
      @(negedge clk);
      chk("stall_count_final", 400, stall_count, exp_stall_count());
      $display("stall_count=%0d", stall_count);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (CPU port) and an external loader/debug master (EXT port).
- Drives the memory's write-enable, address and write-data inputs.
- Returns read data to both requesters.
- Raises a stall toward the hazard unit whenever a CPU access is not granted.
- CPU has priority. EXT is protected from starvation and may hold the memory for short bursts.

Parameters:
- DATA_WIDTH, 32, data word width.
- ADDRESS_WIDTH, 32, memory address width.
- STARVE_LIMIT, 4, consecutive denied EXT-request cycles before EXT is forced a grant (≥1).
- BURST_MAX, 4, maximum consecutive EXT beats per ownership (≥1).

Ports:
- i_CLK  in  1  clock; all state updates on the rising edge.
- i_RST  in  1  reset; synchronous, active-high.
- i_CpuReq  in  1  MEM-stage access request (load or store).
- i_CpuWe  in  1  CPU store.
- i_CpuAddr  in  ADDRESS_WIDTH  CPU address (ALU result).
- i_CpuWData  in  DATA_WIDTH  CPU store data, already forwarded.
- o_CpuRData  out  DATA_WIDTH  CPU load data; combinational from memory.
- o_CpuStall  out  1  to hazard unit; freeze pipeline.
- i_ExtReq  in  1  EXT access request.
- i_ExtWe  in  1  EXT write.
- i_ExtAddr  in  ADDRESS_WIDTH  EXT address.
- i_ExtWData  in  DATA_WIDTH  EXT write data.
- o_ExtGnt  out  1  EXT beat accepted this cycle.
- o_ExtRData  out  DATA_WIDTH  registered EXT read data.
- o_ExtRValid  out  1  o_ExtRData valid.
- o_MemWe  out  1  memory write enable.
- o_MemAddr  out  ADDRESS_WIDTH  memory address.
- o_MemWData  out  DATA_WIDTH  memory write data.
- i_MemRData  in  DATA_WIDTH  memory read data (combinational read).
- o_StallCount  out  32  CPU stall-cycle count (see Optional Feature).

Behaviour:
- Memory interface: read is combinational; write commits on the i_CLK edge when o_MemWe=1.
- State register: S_CPU (CPU owns memory) and S_EXT (EXT burst in progress).
- Counters:
  - starve_cnt, width clog2(STARVE_LIMIT+1), saturating.
  - beat_cnt, width clog2(BURST_MAX+1).
- Grant selection (combinational from state, counters and requests):
  - S_CPU: EXT is granted when i_ExtReq && (!i_CpuReq || starve_cnt==STARVE_LIMIT). Otherwise CPU is granted when i_CpuReq.
  - S_EXT: EXT is granted while i_ExtReq && beat_cnt<BURST_MAX. Otherwise CPU is granted when i_CpuReq.
- Memory mux:
  - The granted side drives o_MemAddr and o_MemWData, and o_MemWe = that side's We.
  - With no grant: o_MemWe=0 and address/data select the CPU inputs. No write can occur in this case.
- o_CpuStall = i_CpuReq && !cpu_gnt.
- o_ExtGnt = ext_gnt.
- o_CpuRData = i_MemRData at all times. It is only meaningful when not stalled.
- EXT read response:
  - On an EXT read grant (!i_ExtWe), the next edge captures o_ExtRData <= i_MemRData and sets o_ExtRValid=1.
  - Otherwise o_ExtRValid=0.
  - Latency is exactly 1 cycle after grant. EXT writes produce no o_ExtRValid.
- State transitions:
  - S_CPU→S_EXT on any EXT grant, with beat_cnt<=1.
  - In S_EXT, an EXT grant increments beat_cnt.
  - S_EXT→S_CPU when i_ExtReq=0 or beat_cnt==BURST_MAX in the evaluating cycle (that cycle gives no EXT grant); beat_cnt<=0.
- starve_cnt rules:
  - Increments (saturating) when i_ExtReq && !ext_gnt.
  - Clears on any ext_gnt.
  - Clears when i_ExtReq=0.
- Simultaneous requests with starve_cnt<STARVE_LIMIT: CPU wins and EXT waits.
- Burst termination: a CPU waiting in S_EXT receives the grant in the same cycle the burst ends.
- EXT dropping i_ExtReq mid-burst returns ownership immediately with no dead cycle.
- Reset:
  - State S_CPU; starve_cnt=0, beat_cnt=0; o_ExtRValid=0; o_ExtRData=0; o_StallCount=0.
  - Combinational outputs follow inputs.
  - Reset mid-burst aborts the burst. A pending EXT read response is dropped (o_ExtRValid=0 the next cycle).
- No writes are issued while i_RST=1: o_MemWe is forced to 0.

Optional Feature:
- Macro DMEM_ARB_PERF_CNT_EN.
- Defined: o_StallCount is a 32-bit register that increments each cycle o_CpuStall=1, wraps at 2^32, and clears on reset.
- Undefined: the counter is not built and o_StallCount is tied to 0.

Decomposition:
- Shared package: state encoding typedef (S_CPU=1'b0, S_EXT=1'b1) and grant-source constants (GNT_NONE/GNT_CPU/GNT_EXT).
- One natural sub-module: the existing mux_2_to_1, instantiated twice for address and write-data selection. All else stays inline.

Test Plan:
- CPU-only traffic:
  - Store 0xDEADBEEF to 0x10, then load 0x10 → o_CpuStall=0 throughout; o_CpuRData=0xDEADBEEF.
- EXT-only access:
  - EXT write 0x55 at 0x20, then read 0x20 → o_ExtGnt=1 each beat; o_ExtRValid=1 one cycle after the read grant with o_ExtRData=0x55.
- Starvation, STARVE_LIMIT=4:
  - i_CpuReq and i_ExtReq held high → CPU granted 4 cycles, then EXT granted, with o_CpuStall=1 for that EXT beat.
- Burst limit, BURST_MAX=4, both requesting from S_EXT entry → exactly 4 EXT grants, then a CPU grant the next cycle.
- Burst early exit:
  - EXT drops request after 2 beats while CPU waits → CPU granted the same cycle and stall deasserts.
- Reset mid-burst:
  - i_RST asserted one cycle after an EXT read grant → o_ExtRValid=0, state S_CPU, o_StallCount=0 (with DMEM_ARB_PERF_CNT_EN), and no memory write that cycle.
